imem_responder: RTL

- Instruction-memory responder: the far end of the core's fetch interface.
- Accepts a 10-bit line address and returns a registered 64-bit dual-instruction bundle; honours the core's front-end advance signal.
- Contains a loader FSM that fills the array from a 32-bit valid/ready word stream, and gates fetch output to NOPs until a program is loaded.

---
 rtl/imem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: registered dual-instruction fetch port plus a
// loader FSM that fills the line array from a 32-bit valid/ready word stream.
module imem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              advance_i,
  output logic [63:0]       data_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [31:0]       load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              running_o,
  output logic [ADDR_W:0]   lines_o,
  output logic              overflow_o
);

  localparam int unsigned LINE_W = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [LINE_W-1:0] NOP_LINE = {NOP, NOP};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    lines_d, lines_inc;
  logic                overflow_d;
  logic [WORD_W-1:0]   held_q, held_d;
  logic                accept;
  logic                we;
  logic [LINE_W-1:0]   wdata;
  logic [LINE_W-1:0]   mem [DEPTH];

  assign accept    = load_valid_i && load_ready_o;
  assign lines_inc = (lines_o == CNT_W'(DEPTH)) ? lines_o : lines_o + CNT_W'(1);

  // State register and loader bookkeeping.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      lines_o      <= '0;
      overflow_o   <= 1'b0;
      held_q       <= NOP;
      load_ready_o <= 1'b0;
      running_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lines_o      <= lines_d;
      overflow_o   <= overflow_d;
      held_q       <= held_d;
      load_ready_o <= (state_d == LOAD_LO) || (state_d == LOAD_HI);
      running_o    <= (state_d == RUN);
    end
  end

  // Next-state and line-assembly logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lines_d    = lines_o;
    overflow_d = overflow_o;
    held_d     = held_q;
    we         = 1'b0;
    wdata      = NOP_LINE;
    case (state_q)
      IDLE, RUN: begin
        if (load_start_i) begin
          state_d    = LOAD_LO;
          ptr_d      = '0;
          lines_d    = '0;
          overflow_d = 1'b0;
        end
      end
      LOAD_LO: begin
        if (accept) begin
          held_d = load_data_i;
          if (load_last_i) begin
            // Odd-length program: pad the final line with a NOP in slot 1.
            we      = 1'b1;
            wdata   = {load_data_i, NOP};
            lines_d = lines_inc;
            state_d = RUN;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      LOAD_HI: begin
        if (accept) begin
          we      = 1'b1;
          wdata   = {held_q, load_data_i};
          ptr_d   = ptr_q + ADDR_W'(1);
          lines_d = lines_inc;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            overflow_d = 1'b1;
          end
          state_d = load_last_i ? RUN : LOAD_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line array; intentionally not reset.
  always_ff @(posedge clock_i) begin
    if (we) begin
      mem[ptr_q] <= wdata;
    end
  end

  // Fetch port: NOPs outside RUN so a partially loaded array is never seen.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o <= NOP_LINE;
    end else if (state_q == RUN) begin
      if (advance_i) begin
        data_o <= mem[addr_i];
      end
    end else begin
      data_o <= NOP_LINE;
    end
  end

endmodule
